// File: rtl/render_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// render_sched_pkg : shared types and widths for the render issue scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package render_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  localparam int X_W          = 11;
  localparam int Y_W          = 10;
  localparam int OUT_W        = 10;
  localparam int PIPE_LATENCY = 276;

endpackage
`default_nettype wire

// File: rtl/sat_updown_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_updown_counter : saturating up/down counter with overflow/underflow flags
// Rev 1.0
// ---------------------------------------------------------------------------
module sat_updown_counter #(
  parameter int WIDTH   = 10,
  parameter int MAX     = 512,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] c_RST = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= c_RST;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != c_MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  // Flag the illegal event even when the opposite event cancels the count change
  assign o_overflow  = i_inc && (r_count == c_MAX);
  assign o_underflow = i_dec && (r_count == '0);
  assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/render_issue_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// render_issue_scheduler : credit-gated raster issue to the pixel pipeline
// Optional drain watchdog: SCHED_WATCHDOG_EN
// Rev 1.0
// ---------------------------------------------------------------------------
module render_issue_scheduler
  import render_sched_pkg::*;
#(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int CREDITS     = 512,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_start_in,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic             valid_out,
  input  logic             rgb_valid_in,
  input  logic             credit_return_in,
  output logic [OUT_W-1:0] outstanding_out,
  output logic             busy_out,
  output logic             frame_done_out,
  output logic             err_out
);

  localparam int             CNT_W    = $clog2(CREDITS + 1);
  localparam logic [X_W-1:0] c_X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(V_ACTIVE - 1);

  sched_state_t     r_state, w_state_nxt;
  logic [X_W-1:0]   r_x, r_x_out;
  logic [Y_W-1:0]   r_y, r_y_out;
  logic             r_valid_out, r_err;
  logic [CNT_W-1:0] w_credits, w_outstanding;
  logic             w_issue, w_last_px, w_abort;
  logic             w_cred_ovf, w_cred_udf, w_outs_ovf, w_outs_udf;

  assign w_last_px = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_issue        = 1'b0;
    busy_out       = (r_state != S_IDLE);
    frame_done_out = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (frame_start_in) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_issue = (w_credits != '0);
        if (w_issue && w_last_px) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_outstanding == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x         <= '0;
      r_y         <= '0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_valid_out <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid_out <= w_issue;
      if (w_issue) begin
        r_x_out <= r_x;
        r_y_out <= r_y;
      end
      if (w_abort) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_issue) begin
        if (r_x == c_X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == c_Y_LAST) ? '0 : r_y + Y_W'(1);
        end else begin
          r_x <= r_x + X_W'(1);
        end
      end
      if (w_cred_ovf || w_cred_udf || w_outs_ovf || w_outs_udf || w_abort) r_err <= 1'b1;
    end
  end

  sat_updown_counter #(.WIDTH(CNT_W), .MAX(CREDITS), .RST_VAL(CREDITS)) u_credits (
    .clk         (clk_in),
    .rst         (rst_in),
    .i_inc       (credit_return_in),
    .i_dec       (w_issue),
    .i_clr       (1'b0),
    .o_count     (w_credits),
    .o_overflow  (w_cred_ovf),
    .o_underflow (w_cred_udf)
  );

  sat_updown_counter #(.WIDTH(CNT_W), .MAX(CREDITS), .RST_VAL(0)) u_outstanding (
    .clk         (clk_in),
    .rst         (rst_in),
    .i_inc       (w_issue),
    .i_dec       (rgb_valid_in),
    .i_clr       (w_abort),
    .o_count     (w_outstanding),
    .o_overflow  (w_outs_ovf),
    .o_underflow (w_outs_udf)
  );

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wdog;
  logic            w_wd_restart;

  // Issue counts as progress too, so a credit-starved frame times out from its last issue
  assign w_wd_restart = w_issue || rgb_valid_in || (w_outstanding == '0);
  assign w_abort      = !w_wd_restart && (r_wdog == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in || w_wd_restart || w_abort) r_wdog <= '0;
    else                                   r_wdog <= r_wdog + WD_W'(1);
  end
`else
  logic w_unused_wdog;
  assign w_unused_wdog = |WDOG_CYCLES;
  assign w_abort       = 1'b0;
`endif

  assign x_out           = r_x_out;
  assign y_out           = r_y_out;
  assign valid_out       = r_valid_out;
  assign outstanding_out = OUT_W'(w_outstanding);
  assign err_out         = r_err;

endmodule
`default_nettype wire
